// File: rtl/upzero_pkg.sv
// Shared definitions for the zero-predictor coefficient updater:
// FSM encoding and default parameter values.
package upzero_pkg;

  localparam int NTAPS_DEF   = 6;
  localparam int DLT_W_DEF   = 17;
  localparam int COEF_W_DEF  = 32;
  localparam int LEAK_SH_DEF = 8;
  localparam int STEP_REF    = 128;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_UPD   = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/upzero_if.sv
// Handshake and host-configuration bundle of upzero_gen.
interface upzero_if
  import upzero_pkg::*;
#(
  parameter int NTAPS  = NTAPS_DEF,
  parameter int DLT_W  = DLT_W_DEF,
  parameter int COEF_W = COEF_W_DEF
);
  localparam int AW = (NTAPS > 1) ? $clog2(NTAPS) : 1;

  logic              ap_start;
  logic              ap_done;
  logic              ap_idle;
  logic              ap_ready;
  logic [DLT_W-1:0]  dlt;
  logic [COEF_W-1:0] step;
  logic              adapt_en;
  logic              cfg_we;
  logic [AW-1:0]     cfg_addr;
  logic [COEF_W-1:0] cfg_d;
  logic [COEF_W-1:0] cfg_q;
  logic [COEF_W-1:0] dlt_q;

  modport master (
    output ap_start, dlt, step, adapt_en, cfg_we, cfg_addr, cfg_d,
    input  ap_done, ap_idle, ap_ready, cfg_q, dlt_q
  );

  modport slave (
    input  ap_start, dlt, step, adapt_en, cfg_we, cfg_addr, cfg_d,
    output ap_done, ap_idle, ap_ready, cfg_q, dlt_q
  );

endinterface

// File: rtl/upzero_tap_upd.sv
// Combinational leak plus sign-sign update for a single zero-predictor tap.
module upzero_tap_upd #(
  parameter int COEF_W  = 32,
  parameter int LEAK_SH = 8
) (
  input  logic [COEF_W-1:0] bli_i,
  input  logic [COEF_W-1:0] dlti_i,
  input  logic              dlt_neg_i,
  input  logic [COEF_W-1:0] step_i,
  input  logic              zflag_i,
  output logic [COEF_W-1:0] bli_o
);

  localparam int EW = COEF_W + LEAK_SH;

  logic signed [EW-1:0] b_ext_s;
  logic signed [EW-1:0] shl_s;
  logic signed [EW-1:0] diff_s;
  logic signed [EW-1:0] leak_w_s;
  logic [COEF_W-1:0]    leak_s;
  logic                 neg_s;

  // Leak is bli*(2^LEAK_SH-1)/2^LEAK_SH, floored, evaluated wide enough to never overflow
  always_comb begin
    b_ext_s  = EW'($signed(bli_i));
    shl_s    = b_ext_s <<< LEAK_SH;
    diff_s   = shl_s - b_ext_s;
    leak_w_s = diff_s >>> LEAK_SH;
    leak_s   = leak_w_s[COEF_W-1:0];
    neg_s    = (dlti_i != '0) && (dlti_i[COEF_W-1] ^ dlt_neg_i);
    if (zflag_i) begin
      bli_o = leak_s;
    end else if (neg_s) begin
      bli_o = leak_s - step_i;
    end else begin
      bli_o = leak_s + step_i;
    end
  end

endmodule

// File: rtl/upzero_gen.sv
// Zero-predictor coefficient updater: one tap per cycle leak + sign-sign
// adaptation, followed by a delay-line shift, under an ap_* handshake.
module upzero_gen
  import upzero_pkg::*;
#(
  parameter int NTAPS   = NTAPS_DEF,
  parameter int DLT_W   = DLT_W_DEF,
  parameter int COEF_W  = COEF_W_DEF,
  parameter int LEAK_SH = LEAK_SH_DEF
) (
  input logic     ap_clk,
  input logic     ap_rst,
  upzero_if.slave bus
);

  localparam int            AW        = (NTAPS > 1) ? $clog2(NTAPS) : 1;
  localparam logic [AW-1:0] LAST_IDX  = AW'(NTAPS - 1);
  localparam logic [AW:0]   NTAPS_EXT = (AW + 1)'(NTAPS);

  state_e            state_q, state_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [DLT_W-1:0]  dlt_lat_q, dlt_lat_d;
  logic [COEF_W-1:0] step_lat_q, step_lat_d;
  logic              adapt_lat_q, adapt_lat_d;
  logic              zflag_q, zflag_d;
  logic              done_q, done_d;
  logic              idle_q, idle_d;
  logic [COEF_W-1:0] bli_q  [NTAPS];
  logic [COEF_W-1:0] bli_d  [NTAPS];
  logic [COEF_W-1:0] dlti_q [NTAPS];
  logic [COEF_W-1:0] dlti_d [NTAPS];

  logic              addr_ok_s;
  logic [COEF_W-1:0] dlt_ext_s;
  logic [COEF_W-1:0] upd_s;
  logic [COEF_W-1:0] cfg_q_s;
  logic [COEF_W-1:0] dlt_rd_s;

  assign addr_ok_s = ({1'b0, bus.cfg_addr} < NTAPS_EXT);
  assign dlt_ext_s = COEF_W'($signed(dlt_lat_q));

  upzero_tap_upd #(
    .COEF_W  (COEF_W),
    .LEAK_SH (LEAK_SH)
  ) u_tap_upd (
    .bli_i     (bli_q[idx_q]),
    .dlti_i    (dlti_q[idx_q]),
    .dlt_neg_i (dlt_lat_q[DLT_W-1]),
    .step_i    (step_lat_q),
    .zflag_i   (zflag_q),
    .bli_o     (upd_s)
  );

  always_comb begin
    if (addr_ok_s) begin
      cfg_q_s  = bli_q[bus.cfg_addr];
      dlt_rd_s = dlti_q[bus.cfg_addr];
    end else begin
      cfg_q_s  = '0;
      dlt_rd_s = '0;
    end
  end

  assign bus.cfg_q    = cfg_q_s;
  assign bus.dlt_q    = dlt_rd_s;
  assign bus.ap_done  = done_q;
  assign bus.ap_ready = done_q;
  assign bus.ap_idle  = idle_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    dlt_lat_d   = dlt_lat_q;
    step_lat_d  = step_lat_q;
    adapt_lat_d = adapt_lat_q;
    zflag_d     = zflag_q;
    bli_d       = bli_q;
    dlti_d      = dlti_q;
    case (state_q)
      ST_IDLE: begin
        // A host write lands on the same edge as a start, so the update sees it
        if (bus.cfg_we && addr_ok_s) begin
          bli_d[bus.cfg_addr] = bus.cfg_d;
        end else begin
          bli_d = bli_q;
        end
        if (bus.ap_start) begin
          dlt_lat_d   = bus.dlt;
          step_lat_d  = bus.step;
          adapt_lat_d = bus.adapt_en;
          zflag_d     = (bus.dlt == '0);
          idx_d       = '0;
          state_d     = ST_UPD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_UPD: begin
        if (adapt_lat_q) begin
          bli_d[idx_q] = upd_s;
        end else begin
          bli_d = bli_q;
        end
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = ST_SHIFT;
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
      ST_SHIFT: begin
        for (int k = NTAPS - 1; k > 0; k--) begin
          dlti_d[k] = dlti_q[k-1];
        end
        dlti_d[0] = dlt_ext_s;
        state_d   = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    done_d = (state_d == ST_DONE);
    idle_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      dlt_lat_q   <= '0;
      step_lat_q  <= '0;
      adapt_lat_q <= 1'b0;
      zflag_q     <= 1'b0;
      done_q      <= 1'b0;
      idle_q      <= 1'b1;
      for (int k = 0; k < NTAPS; k++) begin
        bli_q[k]  <= '0;
        dlti_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      dlt_lat_q   <= dlt_lat_d;
      step_lat_q  <= step_lat_d;
      adapt_lat_q <= adapt_lat_d;
      zflag_q     <= zflag_d;
      done_q      <= done_d;
      idle_q      <= idle_d;
      bli_q       <= bli_d;
      dlti_q      <= dlti_d;
    end
  end

endmodule

// File: tb/tb_upzero_gen.sv
// Self-checking bench for upzero_gen: directed vector table, handshake
// sequences and randomized updates against an arithmetic reference model.
`timescale 1ns/1ps
module tb_upzero_gen;
  import upzero_pkg::*;

  localparam int NT = NTAPS_DEF;

  logic ap_clk = 1'b0;
  logic ap_rst;
  always #5 ap_clk = ~ap_clk;

  upzero_if bus ();
  upzero_gen dut (.ap_clk(ap_clk), .ap_rst(ap_rst), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;
  int m_bli  [NT];
  int m_dlti [NT];

  typedef struct {
    bit         rst;
    bit         we;
    bit         same;
    logic [2:0] wa;
    int         wd;
    int         d;
    bit         a;
    logic [2:0] ca;
    int         eb;
    int         ed;
    logic [2:0] cb;
    int         eb2;
    int         ed2;
  } vec_t;
  vec_t tv [6];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)",
               name, $signed(got), got, $signed(exp), exp);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < NT; i++) begin
      m_bli[i]  = 0;
      m_dlti[i] = 0;
    end
  endtask

  // Reference: floor(b*(2^L-1)/2^L), then +/-step by sign agreement, then delay shift
  task automatic model_update(input int d, input int s, input bit a);
    longint t;
    int lk;
    bit neg;
    for (int i = 0; i < NT; i++) begin
      t  = longint'(m_bli[i]) * ((longint'(1) << LEAK_SH_DEF) - 1);
      t  = t >>> LEAK_SH_DEF;
      lk = int'(t);
      neg = (m_dlti[i] != 0) && ((m_dlti[i] < 0) != (d < 0));
      if (a) m_bli[i] = (d == 0) ? lk : (neg ? lk - s : lk + s);
    end
    for (int k = NT - 1; k > 0; k--) m_dlti[k] = m_dlti[k-1];
    m_dlti[0] = d;
  endtask

  task automatic idle_inputs();
    bus.ap_start = 1'b0;
    bus.cfg_we   = 1'b0;
    bus.cfg_addr = 3'd0;
    bus.cfg_d    = 32'd0;
    bus.dlt      = 17'd0;
    bus.step     = 32'(STEP_REF);
    bus.adapt_en = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    ap_rst = 1'b1;
    tick();
    tick();
    #2 ap_rst = 1'b0;
    model_clear();
  endtask

  task automatic cfg_write(input logic [2:0] addr, input int data);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = addr;
    bus.cfg_d    = 32'(data);
    tick();
    bus.cfg_we   = 1'b0;
  endtask

  task automatic read_tap(input string tag, input logic [2:0] addr, input int eb, input int ed);
    bus.cfg_addr = addr;
    #1;
    check($sformatf("%s bli[%0d]", tag, addr), bus.cfg_q, 32'(eb));
    check($sformatf("%s dlti[%0d]", tag, addr), bus.dlt_q, 32'(ed));
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 8; i++) begin
      if (i < NT) read_tap(tag, 3'(i), m_bli[i], m_dlti[i]);
      else        read_tap(tag, 3'(i), 0, 0);
    end
  endtask

  // Issue one start; lat counts edges with the accept edge as edge 1
  task automatic run_update(input int d, input int s, input bit a, input bit wsame,
                            input logic [2:0] wa, input int wd, output int lat);
    bus.dlt      = 17'(d);
    bus.step     = 32'(s);
    bus.adapt_en = a;
    bus.ap_start = 1'b1;
    bus.cfg_we   = wsame;
    bus.cfg_addr = wa;
    bus.cfg_d    = 32'(wd);
    tick();
    bus.ap_start = 1'b0;
    bus.cfg_we   = 1'b0;
    lat = -1;
    for (int c = 2; c <= 20; c++) begin
      tick();
      if (bus.ap_done) begin
        lat = c;
        check("ap_ready with ap_done", 32'(bus.ap_ready), 32'd1);
        break;
      end
    end
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    int seen;
    int cyc;
    int dc[$];
    idle_inputs();
    ap_rst = 1'b1;

    tv[0] = '{1'b1, 1'b1, 1'b0, 3'd0, 1000,  0, 1'b1, 3'd0,  996,  0, 3'd1,   0,  0};
    tv[1] = '{1'b1, 1'b0, 1'b0, 3'd0,    0,  5, 1'b1, 3'd0,  128,  5, 3'd5, 128,  0};
    tv[2] = '{1'b0, 1'b0, 1'b0, 3'd0,    0, -3, 1'b1, 3'd0,   -1, -3, 3'd1, 255,  5};
    tv[3] = '{1'b1, 1'b1, 1'b0, 3'd2,  500,  7, 1'b0, 3'd2,  500,  0, 3'd0,   0,  7};
    tv[4] = '{1'b1, 1'b1, 1'b1, 3'd0, -1000, 0, 1'b1, 3'd0, -997,  0, 3'd5,   0,  0};
    tv[5] = '{1'b1, 1'b1, 1'b1, 3'd3,  300, -4, 1'b1, 3'd3,  426,  0, 3'd0, 128, -4};

    do_reset();
    check("reset ap_idle", 32'(bus.ap_idle), 32'd1);
    check("reset ap_done", 32'(bus.ap_done), 32'd0);
    check_all("reset");

    for (int v = 0; v < 6; v++) begin
      if (tv[v].rst) do_reset();
      if (tv[v].we && !tv[v].same) cfg_write(tv[v].wa, tv[v].wd);
      run_update(tv[v].d, STEP_REF, tv[v].a, tv[v].we && tv[v].same, tv[v].wa, tv[v].wd, lat);
      check($sformatf("vec%0d latency", v), 32'(lat), 32'd8);
      read_tap($sformatf("vec%0d", v), tv[v].ca, tv[v].eb, tv[v].ed);
      read_tap($sformatf("vec%0d", v), tv[v].cb, tv[v].eb2, tv[v].ed2);
    end

    // Asynchronous reset in the middle of UPD aborts without a done pulse
    do_reset();
    cfg_write(3'd1, 77);
    bus.dlt = 17'd5;
    bus.ap_start = 1'b1;
    tick();
    bus.ap_start = 1'b0;
    tick();
    tick();
    #3 ap_rst = 1'b1;
    #1;
    check("midreset ap_idle", 32'(bus.ap_idle), 32'd1);
    check("midreset ap_done", 32'(bus.ap_done), 32'd0);
    bus.cfg_addr = 3'd1;
    #1;
    check("midreset bli[1]", bus.cfg_q, 32'd0);
    ap_rst = 1'b0;
    model_clear();
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (bus.ap_done) seen++;
    end
    check("midreset no done pulse", 32'(seen), 32'd0);
    check_all("after midreset");

    // Start accepted on the first edge after release
    ap_rst = 1'b1;
    #4 ap_rst = 1'b0;
    bus.dlt = 17'd1;
    bus.ap_start = 1'b1;
    tick();
    bus.ap_start = 1'b0;
    check("first edge start accepted", 32'(bus.ap_idle), 32'd0);
    for (int c = 0; c < 10; c++) tick();

    // Back-to-back updates with ap_start held
    do_reset();
    bus.dlt = 17'd5;
    bus.ap_start = 1'b1;
    cyc = 0;
    for (int c = 0; c < 60; c++) begin
      tick();
      cyc++;
      if (bus.ap_done) dc.push_back(cyc);
      if (dc.size() == 3) begin
        bus.ap_start = 1'b0;
        break;
      end
    end
    check("b2b pulse count", 32'(dc.size()), 32'd3);
    if (dc.size() == 3) begin
      check("b2b first latency", 32'(dc[0]), 32'd8);
      check("b2b spacing 1", 32'(dc[1] - dc[0]), 32'd9);
      check("b2b spacing 2", 32'(dc[2] - dc[1]), 32'd9);
    end
    tick();
    for (int r = 0; r < 3; r++) model_update(5, STEP_REF, 1'b1);
    check_all("b2b");

    // Start and cfg write while in UPD are both ignored
    do_reset();
    bus.dlt = 17'd5;
    bus.ap_start = 1'b1;
    tick();
    bus.ap_start = 1'b0;
    tick();
    tick();
    bus.ap_start = 1'b1;
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = 3'd0;
    bus.cfg_d    = 32'd9999;
    tick();
    bus.ap_start = 1'b0;
    bus.cfg_we   = 1'b0;
    lat = -1;
    for (int c = 5; c <= 20; c++) begin
      tick();
      if (bus.ap_done) begin
        lat = c;
        break;
      end
    end
    check("busy start latency", 32'(lat), 32'd8);
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (bus.ap_done || !bus.ap_idle) seen++;
    end
    check("busy start not queued", 32'(seen), 32'd0);
    model_update(5, STEP_REF, 1'b1);
    check_all("busy write discarded");
    cfg_write(3'd6, 1234);
    check_all("addr6 write discarded");

    // Randomized updates against the reference model
    do_reset();
    for (int n = 0; n < 40; n++) begin
      logic signed [16:0] r17;
      logic [2:0] wa;
      int wd, d, s;
      bit a, we, same;
      we   = ($urandom_range(0, 3) == 0);
      same = we && ($urandom_range(0, 1) == 1);
      wa   = 3'($urandom_range(0, 7));
      wd   = int'($urandom);
      if (we && !same) cfg_write(wa, wd);
      if (we && wa < 3'(NT)) m_bli[wa] = wd;
      r17 = 17'($urandom);
      d = ($urandom_range(0, 3) == 0) ? 0 : int'(r17);
      s = ($urandom_range(0, 1) == 1) ? STEP_REF : int'($urandom_range(0, 4095));
      a = ($urandom_range(0, 7) != 0);
      run_update(d, s, a, same, wa, wd, lat);
      check($sformatf("rand%0d latency", n), 32'(lat), 32'd8);
      model_update(d, s, a);
      check_all($sformatf("rand%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/upzero_gen.md
UPZERO_GEN -- requirements
Module: upzero_gen

Interface
REQ-001 Parameter NTAPS, default 6: number of zero-predictor taps; legal range 2..16.
REQ-002 Parameter DLT_W, default 17: width of signed dlt input.
REQ-003 Parameter COEF_W, default 32: width of signed coefficient (bli) and delay-line (dlti) entries; must be at least DLT_W.
REQ-004 Parameter LEAK_SH, default 8: leakage shift.
REQ-005 Ports:
- ap_clk, input, 1: sole clock, rising edge.
- ap_rst, input, 1: asynchronous, active-high reset.
- ap_start, input, 1: request one update.
- ap_done, output, 1: one-cycle completion pulse.
- ap_idle, output, 1: FSM in IDLE.
- ap_ready, output, 1: equals ap_done.
- dlt, input, DLT_W: signed quantised difference, sampled at start.
- step, input, COEF_W: unsigned sign-sign step, sampled at start; reference setting 128.
- adapt_en, input, 1: 0 shifts the delay line only and leaves coefficients unchanged; sampled at start.
- cfg_we, input, 1: host coefficient write.
- cfg_addr, input, clog2(NTAPS): host tap select.
- cfg_d, input, COEF_W: host write data.
- cfg_q, output, COEF_W: bli[cfg_addr], combinational read.
- dlt_q, output, COEF_W: dlti[cfg_addr], combinational read.

Function
REQ-006 The block SHALL hold bli[0..NTAPS-1] and dlti[0..NTAPS-1] in internal registers.
REQ-007 FSM states SHALL be IDLE, UPD, SHIFT, DONE, with these transitions:
- IDLE to UPD when ap_start=1.
- UPD to SHIFT after tap NTAPS-1.
- SHIFT to DONE.
- DONE to IDLE.
REQ-008 On IDLE with ap_start=1, dlt, step and adapt_en SHALL be latched, the tap index set to 0, and zflag set to (dlt==0).
REQ-009 UPD SHALL process one tap per cycle, index i=0..NTAPS-1.
REQ-010 The leak term SHALL be leak = ((bli[i]<<LEAK_SH) - bli[i]) >>> LEAK_SH, computed at COEF_W+LEAK_SH bits with no intermediate truncation.
REQ-011 The result SHALL be truncated to COEF_W bits.
REQ-012 If zflag=1, bli[i] SHALL become leak.
REQ-013 If zflag=0, bli[i] SHALL become leak + (neg ? -step : +step), where neg = (dlti[i]!=0) && (sign(dlti[i]) xor sign(dlt)); COEF_W wraps modulo 2^COEF_W.
REQ-014 If the latched adapt_en=0, UPD SHALL leave every bli unchanged.
REQ-015 SHIFT SHALL set dlti[k]=dlti[k-1] for k=NTAPS-1 down to 1, and dlti[0]=sign-extended latched dlt.
REQ-016 ap_done and ap_ready SHALL be 1 only in DONE.
REQ-017 Latency from the start-accept edge to ap_done SHALL be NTAPS+2 cycles, i.e. 8 for the default NTAPS.
REQ-018 ap_start held high SHALL give back-to-back updates, the next being accepted in the cycle after DONE.
REQ-019 ap_start SHALL be ignored outside IDLE.
REQ-020 cfg_we SHALL write bli[cfg_addr] only in IDLE and be ignored otherwise.
REQ-021 If cfg_we and ap_start are both asserted in IDLE, the write SHALL complete first and the update SHALL use the written value.
REQ-022 cfg_addr >= NTAPS SHALL read 0 and discard writes.

Reset
REQ-023 ap_rst SHALL asynchronously force: state IDLE, all bli=0, all dlti=0, tap index 0, ap_done=0, ap_ready=0, ap_idle=1, cfg_q=0, dlt_q=0.
REQ-024 Reset asserted mid-update SHALL abort it with no ap_done pulse.
REQ-025 The block SHALL accept a start on the first edge after reset deasserts.

Structure
REQ-026 The FSM state encoding and the default parameters (6, 17, 32, 8, step 128) SHALL live in the shared package upzero_pkg.
REQ-027 One sub-module, upzero_tap_upd, SHALL implement the combinational per-tap arithmetic of REQ-010 to REQ-013.
REQ-028 No other hierarchy SHALL be added.

Verification (defaults, step=128)
REQ-029 Reset: assert ap_rst asynchronously mid-UPD, then release; all taps read 0, ap_idle=1, no ap_done pulse.
REQ-030 Leak only: cfg write bli[0]=1000, start with dlt=0; after 8 cycles ap_done=1, bli[0]=996, dlti[0]=0.
REQ-031 Sign-sign update:
- From zeros, start dlt=5: all bli=128, dlti[0]=5.
- Then start dlt=-3: bli[0]=-1, bli[1..5]=255, dlti[0]=-3, dlti[1]=5.
REQ-032 Freeze: preload bli[2]=500, start adapt_en=0 with dlt=7; bli[2]=500 and dlti[0]=7.
REQ-033 Handshake:
- ap_start held for 3 updates gives ap_done pulses 9 cycles apart.
- A start during UPD is ignored.
- A cfg write during UPD is discarded.
REQ-034 Boundaries:
- cfg_addr=6 reads 0.
- bli=-1000 with dlt=0 gives -997, i.e. arithmetic-shift floor.
